// File: rtl/ring_arbiter_if.sv
// rtl/ring_arbiter_if.sv - request/grant bundle between requesters and the ring arbiter
interface ring_arbiter_if #(
    parameter int N = 8
) ();
    localparam int IW = $clog2(N);

    logic [N-1:0]  req;
    logic          done;
    logic [N-1:0]  grant;
    logic [IW-1:0] owner;
    logic          busy;
    logic          timeout;

    // Requester side drives requests and the release strobe
    modport master (
        output req,
        output done,
        input  grant,
        input  owner,
        input  busy,
        input  timeout
    );

    // Arbiter side
    modport slave (
        input  req,
        input  done,
        output grant,
        output owner,
        output busy,
        output timeout
    );
endinterface

// File: rtl/ring_arbiter.sv
// rtl/ring_arbiter.sv - round-robin ring arbiter with hold limit and guard cycle
module ring_arbiter #(
    parameter int N        = 8,
    parameter int HOLD_MAX = 15
) (
    input  logic           clk,
    input  logic           init,
    ring_arbiter_if.slave  bus
);
    localparam int IW = $clog2(N);
    localparam logic [7:0] HOLD_SAT  = 8'(HOLD_MAX);
    localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  ptr_q, ptr_d;
    logic [N-1:0]  grant_q, grant_d;
    logic [IW-1:0] owner_q, owner_d;
    logic          busy_q, busy_d;
    logic          timeout_q, timeout_d;
    logic [7:0]    hold_q, hold_d;

    logic [IW-1:0] ptr_idx;
    logic [N-1:0]  pick;
    logic [IW-1:0] pick_idx;
    logic          pick_valid;

    logic          owner_req;
    logic          norm_rel;
    logic          limit_hit;

    // Binary index of the one-hot priority pointer
    always_comb begin
        ptr_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (ptr_q[i]) begin
                ptr_idx = IW'(i);
            end
        end
    end

    // First active request scanning upward from the pointer, wrapping N-1 -> 0
    always_comb begin
        int idx;
        logic [IW-1:0] pos;
        pick       = '0;
        pick_idx   = '0;
        pick_valid = 1'b0;
        idx        = 0;
        pos        = '0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr_idx) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            pos = IW'(idx);
            if (!pick_valid && bus.req[pos]) begin
                pick_valid = 1'b1;
                pick[pos]  = 1'b1;
                pick_idx   = pos;
            end
        end
    end

    // Release causes; only the owner's request and done matter while granted
    always_comb begin
        owner_req = bus.req[owner_q];
        norm_rel  = bus.done | ~owner_req;
        limit_hit = (hold_q == HOLD_LAST);
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        grant_d   = grant_q;
        owner_d   = owner_q;
        busy_d    = busy_q;
        hold_d    = hold_q;
        timeout_d = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (pick_valid) begin
                    state_d = S_GRANT;
                    grant_d = pick;
                    owner_d = pick_idx;
                    busy_d  = 1'b1;
                    hold_d  = '0;
                end else begin
                    grant_d = '0;
                    owner_d = '0;
                    busy_d  = 1'b0;
                end
            end
            S_GRANT: begin
                hold_d = (hold_q == HOLD_SAT) ? hold_q : 8'(hold_q + 8'd1);
                if (norm_rel || limit_hit) begin
                    // Dropping to IDLE here is what creates the guard cycle
                    state_d   = S_IDLE;
                    grant_d   = '0;
                    owner_d   = '0;
                    busy_d    = 1'b0;
                    ptr_d     = {grant_q[N-2:0], grant_q[N-1]};
                    timeout_d = limit_hit & ~norm_rel;
                end
            end
            default: begin
                state_d = S_IDLE;
                grant_d = '0;
                owner_d = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; init aborts any grant and rewinds the pointer
    always_ff @(posedge clk) begin
        if (init) begin
            state_q   <= S_IDLE;
            ptr_q     <= {{(N-1){1'b0}}, 1'b1};
            grant_q   <= '0;
            owner_q   <= '0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
            hold_q    <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            grant_q   <= grant_d;
            owner_q   <= owner_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
            hold_q    <= hold_d;
        end
    end

    assign bus.grant   = grant_q;
    assign bus.owner   = owner_q;
    assign bus.busy    = busy_q;
    assign bus.timeout = timeout_q;
endmodule
